// File: rtl/sh2_rf_wb_sched.sv
// SH-2 register-file write-back scheduler: merges LD/EX0/EX1 onto RF ports A/B and tracks in-flight loads.
// Optional debug write port enabled by defining SH2_WB_DBG_EN.
module sh2_rf_wb_sched #(
  parameter int LD_DEPTH = 2
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        CE,
  input  logic        LD_ISSUE,
  input  logic [4:0]  LD_ISSUE_RN,
  output logic        LD_ISSUE_RDY,
  input  logic        LD_V,
  input  logic [4:0]  LD_RN,
  input  logic [31:0] LD_D,
  input  logic        EX0_V,
  input  logic [4:0]  EX0_RN,
  input  logic [31:0] EX0_D,
  input  logic        EX1_V,
  input  logic [4:0]  EX1_RN,
  input  logic [31:0] EX1_D,
  output logic        EX_RDY,
  input  logic [4:0]  RS_A,
  input  logic [4:0]  RS_B,
  output logic        HAZ,
  output logic [4:0]  WA_ADDR,
  output logic [31:0] WA_D,
  output logic        WAE,
  output logic [4:0]  WB_ADDR,
  output logic [31:0] WB_D,
  output logic        WBE,
`ifdef SH2_WB_DBG_EN
  input  logic        DBG_WE,
  input  logic [4:0]  DBG_RN,
  input  logic [31:0] DBG_D,
  output logic        DBG_RDY,
`endif
  output logic        SEQ_ERR
);

  localparam int CW = $clog2(LD_DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(LD_DEPTH);

  // Outstanding-load FIFO kept as a shift queue; entry 0 is always the oldest load
  logic [4:0]    r_q     [LD_DEPTH];
  logic [4:0]    w_q_nxt [LD_DEPTH];
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_ins;
  logic [CW-1:0] w_cnt_nxt;
  logic          w_pop;
  logic          w_head_pop;
  logic          w_push;
  logic          w_seq_bad;
  logic          w_haz;
  logic          r_seq_err;

  logic          w_a_v;
  logic [4:0]    w_a_addr;
  logic [31:0]   w_a_d;
  logic          w_b_v;
  logic [4:0]    w_b_addr;
  logic [31:0]   w_b_d;
  logic          w_ex_rdy;

  logic          r_wae;
  logic [4:0]    r_wa_addr;
  logic [31:0]   r_wa_d;
  logic          r_wbe;
  logic [4:0]    r_wb_addr;
  logic [31:0]   r_wb_d;

  assign LD_ISSUE_RDY = (r_cnt < DEPTH_C);
  assign w_pop        = CE & LD_V;
  assign w_head_pop   = w_pop & (r_cnt != '0);
  assign w_push       = CE & LD_ISSUE & LD_ISSUE_RDY;
  assign w_seq_bad    = w_pop & ((r_cnt == '0) | (LD_RN != r_q[0]));
  assign w_ins        = r_cnt - CW'(w_head_pop);
  assign w_cnt_nxt    = w_ins + CW'(w_push);

  always_comb begin
    for (int i = 0; i < LD_DEPTH; i++) w_q_nxt[i] = r_q[i];
    if (w_head_pop) begin
      for (int i = 1; i < LD_DEPTH; i++) w_q_nxt[i-1] = r_q[i];
    end
    if (w_push) begin
      for (int i = 0; i < LD_DEPTH; i++) begin
        if (CW'(i) == w_ins) w_q_nxt[i] = LD_ISSUE_RN;
      end
    end
  end

  // The head being retired this cycle no longer blocks decode; a load issued now is not yet busy
  always_comb begin
    w_haz = 1'b0;
    for (int i = 0; i < LD_DEPTH; i++) begin
      if ((CW'(i) < r_cnt) && !((i == 0) && w_head_pop) &&
          ((r_q[i] == RS_A) || (r_q[i] == RS_B)))
        w_haz = 1'b1;
    end
  end

  assign HAZ = w_haz;

  assign w_ex_rdy = !(LD_V && EX0_V && EX1_V);
  assign EX_RDY   = w_ex_rdy;

`ifdef SH2_WB_DBG_EN
  assign DBG_RDY = !LD_V && !EX0_V && !EX1_V;
`endif

  // Oldest source lands on port A; the younger one on port B wins an address clash in the RF
  always_comb begin
    w_a_v    = 1'b0;
    w_a_addr = '0;
    w_a_d    = '0;
    w_b_v    = 1'b0;
    w_b_addr = '0;
    w_b_d    = '0;
    if (LD_V) begin
      w_a_v    = 1'b1;
      w_a_addr = LD_RN;
      w_a_d    = LD_D;
      if (w_ex_rdy) begin
        if (EX0_V) begin
          w_b_v    = 1'b1;
          w_b_addr = EX0_RN;
          w_b_d    = EX0_D;
        end else if (EX1_V) begin
          w_b_v    = 1'b1;
          w_b_addr = EX1_RN;
          w_b_d    = EX1_D;
        end
      end
    end else if (EX0_V) begin
      w_a_v    = 1'b1;
      w_a_addr = EX0_RN;
      w_a_d    = EX0_D;
      if (EX1_V) begin
        w_b_v    = 1'b1;
        w_b_addr = EX1_RN;
        w_b_d    = EX1_D;
      end
    end else if (EX1_V) begin
      w_a_v    = 1'b1;
      w_a_addr = EX1_RN;
      w_a_d    = EX1_D;
    end
`ifdef SH2_WB_DBG_EN
    else if (DBG_WE) begin
      w_a_v    = 1'b1;
      w_a_addr = DBG_RN;
      w_a_d    = DBG_D;
    end
`endif
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_cnt     <= '0;
      for (int i = 0; i < LD_DEPTH; i++) r_q[i] <= '0;
      r_seq_err <= 1'b0;
      r_wae     <= 1'b0;
      r_wa_addr <= '0;
      r_wa_d    <= '0;
      r_wbe     <= 1'b0;
      r_wb_addr <= '0;
      r_wb_d    <= '0;
    end else if (CE) begin
      r_cnt <= w_cnt_nxt;
      for (int i = 0; i < LD_DEPTH; i++) r_q[i] <= w_q_nxt[i];
      if (w_seq_bad) r_seq_err <= 1'b1;
      r_wae <= w_a_v;
      if (w_a_v) begin
        r_wa_addr <= w_a_addr;
        r_wa_d    <= w_a_d;
      end
      r_wbe <= w_b_v;
      if (w_b_v) begin
        r_wb_addr <= w_b_addr;
        r_wb_d    <= w_b_d;
      end
    end
  end

  assign WAE     = r_wae;
  assign WA_ADDR = r_wa_addr;
  assign WA_D    = r_wa_d;
  assign WBE     = r_wbe;
  assign WB_ADDR = r_wb_addr;
  assign WB_D    = r_wb_d;
  assign SEQ_ERR = r_seq_err;

endmodule

// File: tb/tb_sh2_rf_wb_sched.sv
// Bench for sh2_rf_wb_sched: directed scenarios followed by random traffic against a queue-based model.
module tb_sh2_rf_wb_sched;
  localparam int DEPTH = 2;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        CE;
  logic        LD_ISSUE;
  logic [4:0]  LD_ISSUE_RN;
  logic        LD_ISSUE_RDY;
  logic        LD_V;
  logic [4:0]  LD_RN;
  logic [31:0] LD_D;
  logic        EX0_V;
  logic [4:0]  EX0_RN;
  logic [31:0] EX0_D;
  logic        EX1_V;
  logic [4:0]  EX1_RN;
  logic [31:0] EX1_D;
  logic        EX_RDY;
  logic [4:0]  RS_A;
  logic [4:0]  RS_B;
  logic        HAZ;
  logic [4:0]  WA_ADDR;
  logic [31:0] WA_D;
  logic        WAE;
  logic [4:0]  WB_ADDR;
  logic [31:0] WB_D;
  logic        WBE;
  logic        SEQ_ERR;

  sh2_rf_wb_sched #(.LD_DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST_N(RST_N), .CE(CE),
    .LD_ISSUE(LD_ISSUE), .LD_ISSUE_RN(LD_ISSUE_RN), .LD_ISSUE_RDY(LD_ISSUE_RDY),
    .LD_V(LD_V), .LD_RN(LD_RN), .LD_D(LD_D),
    .EX0_V(EX0_V), .EX0_RN(EX0_RN), .EX0_D(EX0_D),
    .EX1_V(EX1_V), .EX1_RN(EX1_RN), .EX1_D(EX1_D),
    .EX_RDY(EX_RDY), .RS_A(RS_A), .RS_B(RS_B), .HAZ(HAZ),
    .WA_ADDR(WA_ADDR), .WA_D(WA_D), .WAE(WAE),
    .WB_ADDR(WB_ADDR), .WB_D(WB_D), .WBE(WBE),
    .SEQ_ERR(SEQ_ERR)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  // Reference model: loads in flight as a plain queue, expected registered outputs
  int          mq[$];
  bit          m_err;
  bit          m_wae, m_wbe;
  logic [4:0]  m_wa_addr, m_wb_addr;
  logic [31:0] m_wa_d, m_wb_d;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    mq.delete();
    m_err = 0;
    m_wae = 0; m_wbe = 0;
    m_wa_addr = '0; m_wb_addr = '0;
    m_wa_d = '0; m_wb_d = '0;
  endtask

  function automatic bit m_haz();
    int lo;
    lo = (CE && LD_V && mq.size() > 0) ? 1 : 0;
    for (int i = lo; i < mq.size(); i++)
      if (mq[i] == int'(RS_A) || mq[i] == int'(RS_B)) return 1'b1;
    return 1'b0;
  endfunction

  task automatic m_step();
    bit          rdy;
    logic [4:0]  wa[$];
    logic [31:0] wd[$];
    if (!CE) return;
    rdy = mq.size() < DEPTH;
    if (LD_V) begin
      if (mq.size() == 0 || mq[0] != int'(LD_RN)) m_err = 1;
      if (mq.size() > 0) void'(mq.pop_front());
    end
    if (LD_ISSUE && rdy) mq.push_back(int'(LD_ISSUE_RN));
    // Age order: load return, then EX primary, then EX secondary (the EX pair only if not stalled)
    if (LD_V) begin wa.push_back(LD_RN); wd.push_back(LD_D); end
    if (!(LD_V && EX0_V && EX1_V)) begin
      if (EX0_V) begin wa.push_back(EX0_RN); wd.push_back(EX0_D); end
      if (EX1_V) begin wa.push_back(EX1_RN); wd.push_back(EX1_D); end
    end
    m_wae = wa.size() > 0;
    m_wbe = wa.size() > 1;
    if (m_wae) begin m_wa_addr = wa[0]; m_wa_d = wd[0]; end
    if (m_wbe) begin m_wb_addr = wa[1]; m_wb_d = wd[1]; end
  endtask

  task automatic idle();
    CE = 1; LD_ISSUE = 0; LD_ISSUE_RN = '0; LD_V = 0; LD_RN = '0; LD_D = '0;
    EX0_V = 0; EX0_RN = '0; EX0_D = '0; EX1_V = 0; EX1_RN = '0; EX1_D = '0;
    RS_A = '0; RS_B = '0;
  endtask

  // Called just after a falling edge with inputs already driven
  task automatic cyc();
    #1;
    chk("ex_rdy", {31'b0, EX_RDY}, {31'b0, !(LD_V && EX0_V && EX1_V)});
    chk("ld_issue_rdy", {31'b0, LD_ISSUE_RDY}, {31'b0, mq.size() < DEPTH});
    chk("haz", {31'b0, HAZ}, {31'b0, m_haz()});
    m_step();
    @(posedge CLK);
    #1;
    chk("wae", {31'b0, WAE}, {31'b0, m_wae});
    chk("wbe", {31'b0, WBE}, {31'b0, m_wbe});
    chk("seq_err", {31'b0, SEQ_ERR}, {31'b0, m_err});
    if (m_wae) begin
      chk("wa_addr", {27'b0, WA_ADDR}, {27'b0, m_wa_addr});
      chk("wa_d", WA_D, m_wa_d);
    end
    if (m_wbe) begin
      chk("wb_addr", {27'b0, WB_ADDR}, {27'b0, m_wb_addr});
      chk("wb_d", WB_D, m_wb_d);
    end
    @(negedge CLK);
  endtask

  task automatic chk_reset_outs();
    chk("rst_wae", {31'b0, WAE}, 32'd0);
    chk("rst_wbe", {31'b0, WBE}, 32'd0);
    chk("rst_wa_addr", {27'b0, WA_ADDR}, 32'd0);
    chk("rst_wa_d", WA_D, 32'd0);
    chk("rst_wb_addr", {27'b0, WB_ADDR}, 32'd0);
    chk("rst_wb_d", WB_D, 32'd0);
    chk("rst_seq_err", {31'b0, SEQ_ERR}, 32'd0);
    chk("rst_haz", {31'b0, HAZ}, 32'd0);
    chk("rst_ld_rdy", {31'b0, LD_ISSUE_RDY}, 32'd1);
  endtask

  initial begin
    idle();
    RST_N = 0;
    m_reset();
    #3;
    chk_reset_outs();
    @(negedge CLK);
    RST_N = 1;

    // Load to R3, hazard, return clears hazard in the same cycle, write lands next cycle
    idle(); LD_ISSUE = 1; LD_ISSUE_RN = 5'd3; RS_A = 5'd3; cyc();
    idle(); RS_A = 5'd3; cyc();
    idle(); RS_A = 5'd3; LD_V = 1; LD_RN = 5'd3; LD_D = 32'hDEADBEEF; cyc();
    chk("ld_r3_wae", {31'b0, WAE}, 32'd1);
    chk("ld_r3_addr", {27'b0, WA_ADDR}, 32'd3);
    chk("ld_r3_data", WA_D, 32'hDEADBEEF);

    // Three sources at once: load first, EX stalls, then EX pair goes through
    idle(); LD_ISSUE = 1; LD_ISSUE_RN = 5'd1; cyc();
    idle(); LD_V = 1; LD_RN = 5'd1; LD_D = 32'h1111_0001;
    EX0_V = 1; EX0_RN = 5'd2; EX0_D = 32'h2222_0002;
    EX1_V = 1; EX1_RN = 5'd4; EX1_D = 32'h4444_0004; cyc();
    chk("stall_wbe", {31'b0, WBE}, 32'd0);
    LD_V = 0; cyc();
    chk("ex_pair_wa", {27'b0, WA_ADDR}, 32'd2);
    chk("ex_pair_wb", {27'b0, WB_ADDR}, 32'd4);

    // Same destination on both ports: EX on port B
    idle(); LD_ISSUE = 1; LD_ISSUE_RN = 5'd5; cyc();
    idle(); LD_V = 1; LD_RN = 5'd5; LD_D = 32'h1;
    EX0_V = 1; EX0_RN = 5'd5; EX0_D = 32'h2; cyc();
    chk("clash_wb_d", WB_D, 32'h2);

    // Fill FIFO, return out of order
    idle(); LD_ISSUE = 1; LD_ISSUE_RN = 5'd7; cyc();
    idle(); LD_ISSUE = 1; LD_ISSUE_RN = 5'd8; cyc();
    idle(); LD_ISSUE = 1; LD_ISSUE_RN = 5'd16; cyc();
    chk("full_rdy", {31'b0, LD_ISSUE_RDY}, 32'd0);
    idle(); LD_V = 1; LD_RN = 5'd8; LD_D = 32'h8888; cyc();
    chk("ooo_seq_err", {31'b0, SEQ_ERR}, 32'd1);
    idle(); RS_A = 5'd8; RS_B = 5'd7; cyc();
    idle(); RS_A = 5'd7; RS_B = 5'd7; cyc();

    // Clock enable low holds everything
    idle(); CE = 0; EX0_V = 1; EX0_RN = 5'd9; EX0_D = 32'h9999; RS_A = 5'd8; cyc();
    CE = 1; cyc();
    chk("ce_wa", {27'b0, WA_ADDR}, 32'd9);

    // Asynchronous reset with a write pending and a load in flight
    idle(); EX0_V = 1; EX0_RN = 5'd10; EX0_D = 32'hA; RS_A = 5'd8; cyc();
    idle(); RS_A = 5'd8;
    #1;
    chk("pre_rst_haz", {31'b0, HAZ}, {31'b0, m_haz()});
    #1;
    RST_N = 0;
    m_reset();
    #1;
    chk_reset_outs();
    @(negedge CLK);
    RST_N = 1;

    // Random traffic, mostly in-order returns
    for (int n = 0; n < 500; n++) begin
      idle();
      CE          = ($urandom % 8) != 0;
      LD_ISSUE    = ($urandom % 3) == 0;
      LD_ISSUE_RN = 5'($urandom % 17);
      LD_V        = (mq.size() > 0) ? (($urandom % 2) == 0) : (($urandom % 25) == 0);
      LD_RN       = (mq.size() > 0 && ($urandom % 12) != 0) ? 5'(mq[0]) : 5'($urandom % 17);
      LD_D        = $urandom;
      EX0_V       = ($urandom % 2) == 0;
      EX0_RN      = 5'($urandom % 17);
      EX0_D       = $urandom;
      EX1_V       = ($urandom % 2) == 0;
      EX1_RN      = 5'($urandom % 17);
      EX1_D       = $urandom;
      RS_A        = (mq.size() > 0 && ($urandom % 2) == 0) ? 5'(mq[$urandom % mq.size()]) : 5'($urandom % 17);
      RS_B        = 5'($urandom % 17);
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
